// File: rtl/lsreg_shift_ctrl.sv
// lsreg_shift_ctrl: takes a word over valid/ready, shifts it MSB-first into a left shift
// register, then captures the register's parallel output. Optional parity bit: LSREG_CTRL_PARITY_EN.
module lsreg_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             sr_x,
    output logic             sr_shift,
    output logic             sr_clr,
    input  logic [WIDTH-1:0] sr_out,
    output logic             busy,
    output logic             done,
`ifdef LSREG_CTRL_PARITY_EN
    output logic             parity_bit,
`endif
    output logic [WIDTH-1:0] result
);

`ifdef LSREG_CTRL_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int            CW       = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    LAST_GAP = 3'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [2:0]       r_gcnt;
    logic [2:0]       w_gcnt_next;
    logic             w_accept;
    logic [WIDTH-1:0] r_hold;
    logic             r_in_ready;
    logic             r_sr_x;
    logic             r_sr_shift;
    logic             r_sr_clr;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    // Bit idx of the outgoing frame: data MSB first, then (optionally) the parity bit.
    function automatic logic frame_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
        logic [WIDTH-1:0] t;
        logic             b;
        t = w << idx;
        if (idx < CW'(WIDTH)) begin
            b = t[WIDTH-1];
        end else begin
            b = even_parity(w);
        end
        return b;
    endfunction

    // Next-state and counter update logic.
    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_gcnt_next = r_gcnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_CLEAR;
                end else begin
                    w_next   = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_next     = S_SHIFT;
                w_cnt_next = {CW{1'b0}};
            end
            S_SHIFT: begin
                if (r_cnt == LAST_BIT) begin
                    w_next = S_CAPTURE;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            S_CAPTURE: begin
                w_gcnt_next = 3'd0;
                if (GAP > 0) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gcnt == LAST_GAP) begin
                    w_next = S_IDLE;
                end else begin
                    w_gcnt_next = r_gcnt + 3'd1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, counters and holding register.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_gcnt  <= 3'd0;
            r_hold  <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_gcnt  <= w_gcnt_next;
            if (w_accept) begin
                r_hold <= in_data;
            end
        end
    end

    // Outputs are registered from the upcoming state so they line up with it cycle for cycle.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_in_ready <= 1'b0;
            r_sr_x     <= 1'b0;
            r_sr_shift <= 1'b0;
            r_sr_clr   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= {WIDTH{1'b0}};
        end else begin
            r_in_ready <= (w_next == S_IDLE);
            r_sr_clr   <= (w_next == S_CLEAR);
            r_sr_shift <= (w_next == S_SHIFT);
            r_sr_x     <= (w_next == S_SHIFT) ? frame_bit(r_hold, w_cnt_next) : 1'b0;
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_CAPTURE);
            if (r_state == S_CAPTURE) begin
                r_result <= sr_out;
            end
        end
    end

`ifdef LSREG_CTRL_PARITY_EN
    logic r_parity;

    // Parity bit presented alongside done.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            r_parity <= 1'b0;
        end else if (w_next == S_CAPTURE) begin
            r_parity <= even_parity(r_hold);
        end
    end

    assign parity_bit = r_parity;
`endif

    assign in_ready = r_in_ready;
    assign sr_x     = r_sr_x;
    assign sr_shift = r_sr_shift;
    assign sr_clr   = r_sr_clr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;

endmodule
